// File: rtl/ibex_rvfi_trace_buffer.sv
// ibex_rvfi_trace_buffer: captures RVFI retirements into a FIFO and streams each as four 32-bit trace beats
module ibex_rvfi_trace_buffer #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned DropCntW = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      enable_i,
  input  logic                      rvfi_valid_i,
  input  logic [63:0]               rvfi_order_i,
  input  logic [31:0]               rvfi_insn_i,
  input  logic                      rvfi_trap_i,
  input  logic                      rvfi_halt_i,
  input  logic                      rvfi_intr_i,
  input  logic [1:0]                rvfi_mode_i,
  input  logic [4:0]                rvfi_rd_addr_i,
  input  logic [31:0]               rvfi_rd_wdata_i,
  input  logic [31:0]               rvfi_pc_rdata_i,
  output logic                      trace_valid_o,
  output logic [31:0]               trace_data_o,
  output logic                      trace_last_o,
  input  logic                      trace_ready_i,
  output logic [$clog2(Depth):0]    fifo_level_o,
  output logic [DropCntW-1:0]       drop_total_o,
  output logic                      overflow_o
);
  localparam int unsigned PW = $clog2(Depth);
  typedef enum logic {IDLE, SEND} state_e;
  state_e state_q, state_d;
  logic [127:0] mem_q [Depth];
  logic [127:0] mem_d [Depth];
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] pend_q, pend_d;
  logic [DropCntW-1:0] drop_q, drop_d;
  logic ovf_q, ovf_d;
  logic full, pop_last, push_try, push, drop;
  logic [127:0] head;
  logic unused_order;
  assign unused_order = ^rvfi_order_i[63:14];
  always_comb begin
    full = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
    trace_valid_o = state_q == SEND;
    trace_last_o = trace_valid_o && idx_q == 2'd3;
    head = mem_q[rptr_q[PW-1:0]];
    // record is packed {wdata, insn, pc, header} so the beat index selects a 32-bit slice
    trace_data_o = trace_valid_o ? head[{idx_q, 5'd0} +: 32] : '0;
    pop_last = trace_valid_o & trace_ready_i & trace_last_o;
    push_try = enable_i & rvfi_valid_i;
    push = push_try & (!full | pop_last);
    drop = push_try & !push;
    mem_d = mem_q;
    if (push) mem_d[wptr_q[PW-1:0]] = {rvfi_rd_wdata_i, rvfi_insn_i, rvfi_pc_rdata_i, pend_q, rvfi_trap_i,
                                       rvfi_intr_i, rvfi_halt_i, rvfi_mode_i, rvfi_rd_addr_i, rvfi_order_i[13:0]};
    wptr_d = wptr_q + (PW+1)'(push);
    rptr_d = rptr_q + (PW+1)'(pop_last);
    idx_d = idx_q + 2'(trace_valid_o & trace_ready_i);
    pend_d = push ? 8'd0 : (drop && pend_q != 8'hff) ? pend_q + 8'd1 : pend_q;
    drop_d = (drop && !(&drop_q)) ? drop_q + DropCntW'(1) : drop_q;
    ovf_d = drop;
    state_d = (wptr_d != rptr_d) ? SEND : IDLE;
    fifo_level_o = wptr_q - rptr_q;
    drop_total_o = drop_q;
    overflow_o = ovf_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      idx_q <= '0;
      pend_q <= '0;
      drop_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      idx_q <= idx_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk_i) mem_q <= mem_d;
endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// tb_ibex_rvfi_trace_buffer: directed vector and corner-case bench for the RVFI trace buffer
module tb_ibex_rvfi_trace_buffer;
  typedef struct packed {
    logic [63:0] order;
    logic [4:0]  flags;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] wd;
  } rec_t;
  typedef struct packed {
    logic        push;
    logic        rdy;
    rec_t        r;
    logic        v;
    logic        l;
    logic [2:0]  lvl;
    logic [31:0] d;
  } vec_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic enable_i = 1'b1;
  logic rvfi_valid_i = 1'b0;
  logic [63:0] rvfi_order_i = '0;
  logic [31:0] rvfi_insn_i = '0;
  logic rvfi_trap_i = 1'b0;
  logic rvfi_halt_i = 1'b0;
  logic rvfi_intr_i = 1'b0;
  logic [1:0] rvfi_mode_i = '0;
  logic [4:0] rvfi_rd_addr_i = '0;
  logic [31:0] rvfi_rd_wdata_i = '0;
  logic [31:0] rvfi_pc_rdata_i = '0;
  logic trace_valid_o;
  logic [31:0] trace_data_o;
  logic trace_last_o;
  logic trace_ready_i = 1'b0;
  logic [2:0] fifo_level_o;
  logic [3:0] drop_total_o;
  logic overflow_o;
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] hdrs [$];
  logic [1:0] bcnt;
  vec_t vt [22];
  ibex_rvfi_trace_buffer #(.Depth(4), .DropCntW(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .rvfi_valid_i(rvfi_valid_i),
    .rvfi_order_i(rvfi_order_i), .rvfi_insn_i(rvfi_insn_i), .rvfi_trap_i(rvfi_trap_i),
    .rvfi_halt_i(rvfi_halt_i), .rvfi_intr_i(rvfi_intr_i), .rvfi_mode_i(rvfi_mode_i),
    .rvfi_rd_addr_i(rvfi_rd_addr_i), .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
    .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .trace_valid_o(trace_valid_o), .trace_data_o(trace_data_o),
    .trace_last_o(trace_last_o), .trace_ready_i(trace_ready_i), .fifo_level_o(fifo_level_o),
    .drop_total_o(drop_total_o), .overflow_o(overflow_o)
  );
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) bcnt <= 2'd0;
    else if (trace_valid_o && trace_ready_i) begin
      if (bcnt == 2'd0) hdrs.push_back(trace_data_o);
      bcnt <= bcnt + 2'd1;
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic rec_t mr(logic [63:0] o, logic [4:0] f, logic [4:0] rd, logic [31:0] pc, logic [31:0] insn,
                              logic [31:0] wd);
    rec_t r;
    r.order = o;
    r.flags = f;
    r.rd = rd;
    r.pc = pc;
    r.insn = insn;
    r.wd = wd;
    return r;
  endfunction
  function automatic rec_t seq_rec(int i);
    return mr(64'(i), 5'd0, 5'(i), 32'h1000 + 32'(i), 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i));
  endfunction
  function automatic vec_t mv(logic p, logic rdy, rec_t r, logic v, logic l, logic [2:0] lvl, logic [31:0] d);
    vec_t x;
    x.push = p;
    x.rdy = rdy;
    x.r = r;
    x.v = v;
    x.l = l;
    x.lvl = lvl;
    x.d = d;
    return x;
  endfunction
  task automatic set_rec(input rec_t r);
    rvfi_order_i = r.order;
    rvfi_trap_i = r.flags[4];
    rvfi_intr_i = r.flags[3];
    rvfi_halt_i = r.flags[2];
    rvfi_mode_i = r.flags[1:0];
    rvfi_rd_addr_i = r.rd;
    rvfi_pc_rdata_i = r.pc;
    rvfi_insn_i = r.insn;
    rvfi_rd_wdata_i = r.wd;
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    enable_i = 1'b1;
    rvfi_valid_i = 1'b0;
    trace_ready_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    hdrs.delete();
  endtask
  initial begin
    rec_t ra, rb, rc, rd, rn;
    int ovf_cnt;
    logic seen;
    ra = mr(64'd7, 5'd0, 5'd1, 32'h100, 32'h0050_0093, 32'h5);
    rb = mr(64'd8, 5'd0, 5'd2, 32'h200, 32'h13, 32'hAA);
    rc = mr(64'hFFFF_0000_0000_3FFF, 5'b10111, 5'd31, 32'hDEAD_BEEC, 32'hFFFF_FFFF, 32'h1234_5678);
    rd = mr(64'd1, 5'd0, 5'd0, 32'h4, 32'h8, 32'hC);
    rn = mr(64'd100, 5'd0, 5'd5, 32'h300, 32'h33, 32'h77);
    vt[0]  = mv(1, 1, ra, 1, 0, 3'd1, 32'h0000_4007);
    vt[1]  = mv(0, 1, ra, 1, 0, 3'd1, 32'h0000_0100);
    vt[2]  = mv(0, 1, ra, 1, 0, 3'd1, 32'h0050_0093);
    vt[3]  = mv(0, 1, ra, 1, 1, 3'd1, 32'h0000_0005);
    vt[4]  = mv(0, 1, ra, 0, 0, 3'd0, 32'h0);
    vt[5]  = mv(1, 1, rb, 1, 0, 3'd1, 32'h0000_8008);
    vt[6]  = mv(0, 1, rb, 1, 0, 3'd1, 32'h0000_0200);
    vt[7]  = mv(0, 0, rb, 1, 0, 3'd1, 32'h0000_0200);
    vt[8]  = mv(0, 0, rb, 1, 0, 3'd1, 32'h0000_0200);
    vt[9]  = mv(0, 0, rb, 1, 0, 3'd1, 32'h0000_0200);
    vt[10] = mv(0, 1, rb, 1, 0, 3'd1, 32'h0000_0013);
    vt[11] = mv(0, 1, rb, 1, 1, 3'd1, 32'h0000_00AA);
    vt[12] = mv(0, 1, rb, 0, 0, 3'd0, 32'h0);
    vt[13] = mv(1, 1, rc, 1, 0, 3'd1, 32'h00BF_FFFF);
    vt[14] = mv(1, 1, rd, 1, 0, 3'd2, 32'hDEAD_BEEC);
    vt[15] = mv(0, 1, rd, 1, 0, 3'd2, 32'hFFFF_FFFF);
    vt[16] = mv(0, 1, rd, 1, 1, 3'd2, 32'h1234_5678);
    vt[17] = mv(0, 1, rd, 1, 0, 3'd1, 32'h0000_0001);
    vt[18] = mv(0, 1, rd, 1, 0, 3'd1, 32'h0000_0004);
    vt[19] = mv(0, 1, rd, 1, 0, 3'd1, 32'h0000_0008);
    vt[20] = mv(0, 1, rd, 1, 1, 3'd1, 32'h0000_000C);
    vt[21] = mv(0, 1, rd, 0, 0, 3'd0, 32'h0);
    do_reset();
    check("reset_state", 64'({trace_valid_o, trace_last_o, trace_data_o, fifo_level_o, drop_total_o, overflow_o}), 64'd0);
    for (int i = 0; i < 22; i++) begin
      set_rec(vt[i].r);
      rvfi_valid_i = vt[i].push;
      trace_ready_i = vt[i].rdy;
      step();
      check($sformatf("vec%0d", i), 64'({trace_valid_o, trace_last_o, fifo_level_o, trace_data_o}),
            64'({vt[i].v, vt[i].l, vt[i].lvl, vt[i].d}));
    end
    rvfi_valid_i = 1'b0;
    // overflow: four records fit, three are dropped, the next accepted header carries the loss
    do_reset();
    ovf_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      set_rec(seq_rec(i));
      rvfi_valid_i = 1'b1;
      step();
      ovf_cnt += int'(overflow_o);
    end
    rvfi_valid_i = 1'b0;
    step();
    ovf_cnt += int'(overflow_o);
    check("ovf_pulses", 64'(ovf_cnt), 64'd3);
    check("ovf_drop_total", 64'(drop_total_o), 64'd3);
    check("ovf_level", 64'(fifo_level_o), 64'd4);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 10 && fifo_level_o != 3'd3; k++) step();
    check("ovf_wait_level3", 64'(fifo_level_o), 64'd3);
    set_rec(rn);
    rvfi_valid_i = 1'b1;
    step();
    rvfi_valid_i = 1'b0;
    for (int k = 0; k < 40 && (trace_valid_o || fifo_level_o != 3'd0); k++) step();
    check("ovf_drained", 64'({trace_valid_o, fifo_level_o}), 64'd0);
    check("ovf_hdr_count", 64'(hdrs.size()), 64'd5);
    if (hdrs.size() == 5) begin
      for (int k = 0; k < 4; k++) check($sformatf("ovf_hdr%0d", k), 64'(hdrs[k]), 64'((32'(k) << 14) | 32'(k)));
      check("ovf_hdr4", 64'(hdrs[4]), 64'h0301_4064);
    end
    // full FIFO accepts a push in the cycle its head's last beat is taken
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_rec(seq_rec(i));
      rvfi_valid_i = 1'b1;
      step();
    end
    rvfi_valid_i = 1'b0;
    check("fp_full_level", 64'(fifo_level_o), 64'd4);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (trace_last_o) break;
    end
    check("fp_last_seen", 64'({trace_last_o, trace_data_o}), 64'({1'b1, 32'hB000_0000}));
    set_rec(rn);
    rvfi_valid_i = 1'b1;
    step();
    rvfi_valid_i = 1'b0;
    check("fp_no_ovf", 64'({overflow_o, drop_total_o}), 64'd0);
    check("fp_level", 64'(fifo_level_o), 64'd4);
    step();
    check("fp_no_ovf_late", 64'(overflow_o), 64'd0);
    // capture disabled: retirements are ignored entirely
    do_reset();
    enable_i = 1'b0;
    trace_ready_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_rec(seq_rec(i));
      rvfi_valid_i = 1'b1;
      step();
      seen |= trace_valid_o | overflow_o;
    end
    rvfi_valid_i = 1'b0;
    enable_i = 1'b1;
    step();
    seen |= trace_valid_o;
    check("en_no_valid", 64'(seen), 64'd0);
    check("en_counters", 64'({drop_total_o, fifo_level_o}), 64'd0);
    // asynchronous reset in the middle of beat 2
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_rec(seq_rec(i));
      rvfi_valid_i = 1'b1;
      step();
    end
    rvfi_valid_i = 1'b0;
    check("ar_pre_drop", 64'(drop_total_o), 64'd1);
    trace_ready_i = 1'b1;
    for (int k = 0; k < 10 && !(trace_valid_o && trace_data_o == 32'hA000_0000); k++) step();
    check("ar_beat2", 64'({trace_valid_o, trace_data_o}), 64'({1'b1, 32'hA000_0000}));
    #2;
    rst_i = 1'b1;
    #1;
    check("ar_immediate", 64'({trace_valid_o, trace_last_o, fifo_level_o, drop_total_o, overflow_o}), 64'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    set_rec(rn);
    rvfi_valid_i = 1'b1;
    step();
    rvfi_valid_i = 1'b0;
    check("ar_restart", 64'({trace_valid_o, trace_last_o, fifo_level_o, trace_data_o}),
          64'({1'b1, 1'b0, 3'd1, 32'h0001_4064}));
    for (int k = 0; k < 10 && trace_valid_o; k++) step();
    check("ar_drained", 64'(trace_valid_o), 64'd0);
    // saturation of the 4-bit drop counter
    do_reset();
    for (int i = 0; i < 24; i++) begin
      set_rec(seq_rec(i));
      rvfi_valid_i = 1'b1;
      step();
      if (i == 17) check("sat_14", 64'(drop_total_o), 64'd14);
      if (i == 18) check("sat_15", 64'(drop_total_o), 64'd15);
    end
    rvfi_valid_i = 1'b0;
    check("sat_hold", 64'({drop_total_o, overflow_o}), 64'({4'd15, 1'b1}));
    step();
    check("sat_final", 64'({drop_total_o, overflow_o}), 64'({4'd15, 1'b0}));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
